mag_comp_seq: RTL
=================

// Module: mag_comp_seq
// PURPOSE
//   Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
//   Sequences one 4-bit equal/greater slice over the operands, MSB nibble first.
//   Uses a start/busy/done handshake and reports eq / a_gt / b_gt.
//   Sits between register-file operands and control logic that needs wide compares without a wide combinational cone.
// PARAMETERS
//   WIDTH    16   operand width in bits; multiple of 4, >= 4
//   NIBBLES  WIDTH/4   derived localparam; number of compare steps
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request a compare; sampled only when busy=0
//   a          in   WIDTH  operand A, captured on accepted start
//   b          in   WIDTH  operand B, captured on accepted start
//   busy       out  1      high while a compare is in progress
//   done       out  1      one-cycle pulse; result valid this cycle
//   eq         out  1      A == B (valid from done, held until next accept)
//   a_gt       out  1      A > B
//   b_gt       out  1      B > A
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high (clk, rst).
//   Reset: state=IDLE; busy=0, done=0, eq=0, a_gt=0, b_gt=0; nibble index cleared.
//   States: IDLE -> CMP -> FIN -> IDLE.
//   IDLE: start=1 at edge t
//     - latch a/b into internal regs
//     - idx=NIBBLES-1
//     - clear result flags
//     - busy=1 from cycle t+1; go CMP
//   CMP: each cycle, compare nibble idx of latched A vs B (slice: equal / A>B / B>A).
//     - First unequal nibble decides; record a_gt or b_gt and freeze them.
//     - Later nibbles never override a frozen decision.
//     - idx==0, or early exit taken -> FIN; otherwise idx decrements.
//   FIN: done=1 for exactly one cycle; busy=0 in FIN.
//     - If no nibble differed, eq=1; else eq=0.
//     - Next state is IDLE. start is also accepted in FIN (back-to-back).
//   Outputs eq/a_gt/b_gt: exactly one is high after done.
//     - All three stay stable until the next accepted start, then clear to 0.
//   start while busy=1: ignored; operands are not re-latched.
//   Input changes on a/b after accept: no effect on the running compare.
//   rst during CMP/FIN: abort immediately; reset values next cycle; no done pulse.
//   Latency with the feature off: fixed, done in cycle t+NIBBLES+1 (t+5 for WIDTH=16).
//   Arithmetic: unsigned only. No carry chain; idx is clog2(NIBBLES) bits, no wrap past 0.
// CONFIGURATION
//   Macro MAG_COMP_SEQ_EARLY_EXIT_EN:
//     Defined: CMP goes to FIN in the cycle the first unequal nibble is found.
//       Latency is t+k+1, where k = 1-based step of the first difference.
//       Equal operands still take NIBBLES steps.
//     Undefined: always scans all NIBBLES steps, giving fixed, data-independent latency.
//   Result values are identical in both builds; only done timing differs.
// TESTING (WIDTH=16)
//   1. a=16'h1234, b=16'h1234, start at t
//        -> done at t+5, eq=1, a_gt=0, b_gt=0.
//   2. a=16'h8000, b=16'h7FFF
//        -> a_gt=1; done at t+5, or t+2 with EARLY_EXIT_EN.
//   3. a=16'h00A4, b=16'h00A5 (difference in LSB nibble only)
//        -> b_gt=1; done at t+5 in both builds.
//   4. Start accepted with a=16'h0001, b=16'h0000; then start=1 with a=16'hFFFF, b=16'h0000 while busy
//        -> second start ignored; result a_gt=1 from the first operands.
//        -> only one done pulse.
//   5. rst=1 at t+2 of a running compare
//        -> at t+3: busy=0, done=0, eq=a_gt=b_gt=0.
//        -> no done pulse; a new start is accepted normally.
//   6. start held high across FIN with a=b=16'hFFFF
//        -> second compare accepted in the FIN cycle.
//        -> flags clear next cycle; second done 5 cycles later with eq=1.

Source files
------------

// File: rtl/mag_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : mag_comp_seq
// Purpose  : Multi-cycle unsigned magnitude comparator. A single 4-bit
//            equal/greater slice is stepped over the latched operands, most
//            significant nibble first, so a wide compare needs no wide
//            combinational cone. Start/busy/done handshake; the result is
//            reported as one-hot eq / a_gt / b_gt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    operand width in bits (multiple of 4, >= 4), default 16
//   NIBBLES  derived: WIDTH/4, number of compare steps
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      compare request, accepted when busy=0 (IDLE or FIN)
//   a      in   WIDTH  operand A, captured on an accepted start
//   b      in   WIDTH  operand B, captured on an accepted start
//   busy   out  1      compare in progress (CMP state)
//   done   out  1      one-cycle pulse, result valid in this cycle
//   eq     out  1      A == B, held until the next accepted start
//   a_gt   out  1      A >  B, held until the next accepted start
//   b_gt   out  1      B >  A, held until the next accepted start
// Build option
//   MAG_COMP_SEQ_EARLY_EXIT_EN : when defined, the scan stops at the first
//   unequal nibble (data-dependent latency). When undefined, all NIBBLES
//   steps are always taken (fixed latency). Results are identical.
// ============================================================================
module mag_comp_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             a_gt,
  output logic             b_gt
);

  localparam int NIBBLES = WIDTH / 4;
  // Keep the index at least one bit wide so a single-nibble build is legal.
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 eq_q, eq_d;
  logic                 a_gt_q, a_gt_d;
  logic                 b_gt_q, b_gt_d;

  logic [3:0]           w_a_nib;
  logic [3:0]           w_b_nib;
  logic                 w_decided;
  logic                 w_last;
  logic                 w_exit;
  logic                 w_accept;

  // The operand registers are shifted left one nibble per compare step, so
  // the nibble selected by idx always sits in the top four bits. This keeps
  // the slice mux out of the datapath entirely.
  assign w_a_nib   = a_q[WIDTH-1 -: 4];
  assign w_b_nib   = b_q[WIDTH-1 -: 4];

  // Once a_gt or b_gt is set the decision is frozen for the rest of the scan.
  assign w_decided = a_gt_q | b_gt_q;
  assign w_last    = (idx_q == '0);

`ifdef MAG_COMP_SEQ_EARLY_EXIT_EN
  logic w_diff;
  // With early exit the scan ends on the first unequal nibble, so a frozen
  // decision is never seen inside CMP; w_decided only guards the full scan.
  assign w_diff = (w_a_nib != w_b_nib) && !w_decided;
  assign w_exit = w_last || w_diff;
`else
  assign w_exit = w_last;
`endif

  // A start is honoured whenever no compare is running, which includes the
  // FIN cycle so back-to-back compares lose no cycle.
  assign w_accept = start && (state_q != S_CMP);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    a_gt_d  = a_gt_q;
    b_gt_d  = b_gt_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_CMP: begin
        if (!w_decided) begin
          if (w_a_nib > w_b_nib) begin
            a_gt_d = 1'b1;
          end else if (w_b_nib > w_a_nib) begin
            b_gt_d = 1'b1;
          end
        end

        a_d = a_q << 4;
        b_d = b_q << 4;

        if (w_exit) begin
          // eq is resolved as the scan leaves CMP so all three flags are
          // already valid in the FIN (done) cycle.
          state_d = S_FIN;
          eq_d    = ~(a_gt_d | b_gt_d);
        end else begin
          idx_d   = idx_q - IDX_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting a new compare overrides whatever IDLE/FIN would have done.
    if (w_accept) begin
      state_d = S_CMP;
      a_d     = a;
      b_d     = b;
      idx_d   = IDX_W'(NIBBLES - 1);
      eq_d    = 1'b0;
      a_gt_d  = 1'b0;
      b_gt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      a_gt_q  <= 1'b0;
      b_gt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      a_gt_q  <= a_gt_d;
      b_gt_q  <= b_gt_d;
    end
  end

  assign busy = (state_q == S_CMP);
  assign done = (state_q == S_FIN);
  assign eq   = eq_q;
  assign a_gt = a_gt_q;
  assign b_gt = b_gt_q;

endmodule
`default_nettype wire
